// File: rtl/sweep_counter_ctrl.sv
// Triangle-sweep sequencer: drives an 8-bit count lo -> hi -> lo for a
// programmed number of sweeps, with optional dwell at each turning point.
module sweep_counter_ctrl #(
  parameter int WIDTH   = 8,
  parameter int CYC_W   = 4,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   lo_lim,
  input  logic [WIDTH-1:0]   hi_lim,
  input  logic [CYC_W-1:0]   num_sweeps,
  input  logic [DWELL_W-1:0] dwell,
  output logic [WIDTH-1:0]   out,
  output logic               up_down,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         state_dbg
);

  // Handshake: start is honoured only in IDLE; busy rises on the edge that
  // accepts it and falls on the edge that pulses done (or on abort).
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_UP       = 3'd1,
    S_DWELL_HI = 3'd2,
    S_DOWN     = 3'd3,
    S_DWELL_LO = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               up_q, up_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [CYC_W-1:0]   nsw_q, nsw_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CYC_W-1:0]   sweep_q, sweep_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      up_q    <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      nsw_q   <= '0;
      dwell_q <= '0;
      sweep_q <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      up_q    <= up_d;
      done_q  <= done_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      nsw_q   <= nsw_d;
      dwell_q <= dwell_d;
      sweep_q <= sweep_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    up_d    = up_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    lo_d    = lo_q;
    hi_d    = hi_q;
    nsw_d   = nsw_q;
    dwell_d = dwell_q;
    sweep_d = sweep_q;
    dcnt_d  = dcnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((lo_lim < hi_lim) && (num_sweeps != '0)) begin
            lo_d    = lo_lim;
            hi_d    = hi_lim;
            nsw_d   = num_sweeps;
            dwell_d = dwell;
            out_d   = lo_lim;
            up_d    = 1'b1;
            sweep_d = '0;
            dcnt_d  = '0;
            state_d = S_UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_UP: begin
        out_d = out_q + WIDTH'(1);
        // lo < hi guarantees hi >= 1, so hi-1 cannot underflow.
        if (out_q == hi_q - WIDTH'(1)) begin
          up_d    = 1'b0;
          dcnt_d  = '0;
          state_d = (dwell_q == '0) ? S_DOWN : S_DWELL_HI;
        end
      end
      S_DWELL_HI: begin
        if (dcnt_q == dwell_q - DWELL_W'(1)) begin
          dcnt_d  = '0;
          state_d = S_DOWN;
        end else begin
          dcnt_d = dcnt_q + DWELL_W'(1);
        end
      end
      S_DOWN: begin
        out_d = out_q - WIDTH'(1);
        if (out_q == lo_q + WIDTH'(1)) begin
          sweep_d = sweep_q + CYC_W'(1);
          dcnt_d  = '0;
          if (sweep_q + CYC_W'(1) == nsw_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            up_d    = 1'b1;
            state_d = (dwell_q == '0) ? S_UP : S_DWELL_LO;
          end
        end
      end
      S_DWELL_LO: begin
        if (dcnt_q == dwell_q - DWELL_W'(1)) begin
          dcnt_d  = '0;
          state_d = S_UP;
        end else begin
          dcnt_d = dcnt_q + DWELL_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything: freeze count/direction, drop to IDLE.
    if (abort) begin
      state_d = S_IDLE;
      out_d   = out_q;
      up_d    = up_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      lo_d    = lo_q;
      hi_d    = hi_q;
      nsw_d   = nsw_q;
      dwell_d = dwell_q;
      sweep_d = sweep_q;
      dcnt_d  = dcnt_q;
    end
  end

  assign out       = out_q;
  assign up_down   = up_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule
